// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of a single FPU between N_REQ requesters, one operation at a time.
// Optional completion watchdog is compiled in when FPU_ARB_TIMEOUT_EN is defined.
module fpu_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [8*N_REQ-1:0]    req_op,
    input  logic [32*N_REQ-1:0]   req_x1,
    input  logic [32*N_REQ-1:0]   req_x2,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [31:0]           resp_y,
    output logic                  resp_ovf,
    output logic                  resp_err,
    output logic                  busy,
    output logic [7:0]            fpu_opcode,
    output logic [31:0]           fpu_x1,
    output logic [31:0]           fpu_x2,
    input  logic [31:0]           fpu_y,
    input  logic                  fpu_ovf,
    input  logic                  fpu_out_valid,
    output logic [1:0]            state_dbg
);

    // Handshake: a request is taken in the cycle where req_valid[g] && req_ready[g];
    // resp_valid is a one-cycle strobe without backpressure.
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     grant_idx;
    logic              grant_found;
    logic [N_REQ-1:0]  owner;
    logic [7:0]        sel_op;
    logic [31:0]       sel_x1, sel_x2;
    logic              op_legal;
    int                cand;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     to_cnt;
    logic              to_hit;
    assign to_hit = (to_cnt == CW'(TIMEOUT - 1));
`endif

    // First requesting index at or above rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = GW'(cand);
            end
        end
    end

    assign sel_op   = req_op[8*int'(grant_idx) +: 8];
    assign sel_x1   = req_x1[32*int'(grant_idx) +: 32];
    assign sel_x2   = req_x2[32*int'(grant_idx) +: 32];
    assign op_legal = (sel_op != 8'd0) && ((sel_op & (sel_op - 8'd1)) == 8'd0);

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_found) state_d = op_legal ? ISSUE : RESP;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (fpu_out_valid) state_d = RESP;
`ifdef FPU_ARB_TIMEOUT_EN
                else if (to_hit) state_d = RESP;
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            resp_valid <= '0;
            resp_y     <= '0;
            resp_ovf   <= 1'b0;
            resp_err   <= 1'b0;
            fpu_opcode <= '0;
            fpu_x1     <= '0;
            fpu_x2     <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fpu_opcode <= '0;
            resp_valid <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        owner  <= req_ready;
                        rr_ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + GW'(1);
                        if (op_legal) begin
                            fpu_opcode <= sel_op;
                            fpu_x1     <= sel_x1;
                            fpu_x2     <= sel_x2;
                        end else begin
                            // Illegal opcodes answer directly; the FPU never sees them.
                            resp_valid <= req_ready;
                            resp_y     <= '0;
                            resp_ovf   <= 1'b0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
`ifdef FPU_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (fpu_out_valid) begin
                        resp_valid <= owner;
                        resp_y     <= fpu_y;
                        resp_ovf   <= fpu_ovf;
                        resp_err   <= 1'b0;
                    end
`ifdef FPU_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        resp_valid <= owner;
                        resp_y     <= '0;
                        resp_ovf   <= 1'b0;
                        resp_err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
